mdu_seq_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit for the single-cycle core.
- Handles every M-extension funct3 that the combinational low-product multiplier cannot:
  - MULH, MULHSU and MULHU, which need the high word;
  - DIV, DIVU, REM and REMU.
- Also executes full 32x32 MUL.
- Sits between decode/register-file read and writeback. o_busy drives the core's PC/pipeline stall, and the writeback mux takes o_result when o_done is high.

---
 rtl/mdu_seq_unit.sv | 157 +++++++++++++++
 tb/tb_mdu_seq_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 iterations plus sign fixup, with a fast path for divide-by-zero and signed overflow.
module mdu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic             pending;   // request latched in IDLE, dispatched on the following edge
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

  // Operand signedness and magnitudes from the latched request.
  logic             a_signed, b_signed, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_result;

  assign a_signed = f3_q[2] ? ~f3_q[0] : (f3_q[1:0] != 2'b11);
  assign b_signed = f3_q[2] ? ~f3_q[0] : ~f3_q[1];
  assign sign_a   = a_signed & a_q[WIDTH-1];
  assign sign_b   = b_signed & b_q[WIDTH-1];
  assign mag_a    = sign_a ? -a_q : a_q;
  assign mag_b    = sign_b ? -b_q : b_q;

  assign div_zero    = f3_q[2] & (b_q == '0);
  assign div_ovf     = f3_q[2] & ~f3_q[0] & (a_q == MIN_NEG) & (b_q == ALL_ONES);
  assign fast        = div_zero | div_ovf;
  assign fast_result = div_zero ? (f3_q[1] ? a_q : ALL_ONES)
                                : (f3_q[1] ? '0  : MIN_NEG);

  // One iteration of each algorithm.
  logic [WIDTH:0] mul_sum, div_shift;
  logic           div_take;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_take  = div_shift >= {1'b0, opnd};

  // Sign fixup and result selection in FIN.
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_result;

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -acc_lo : acc_lo;
  assign rem_s  = neg_r ? -acc_hi : acc_hi;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fin_result = '0;
    if (f3_q[2])             fin_result = f3_q[1] ? rem_s : quo_s;
    else if (f3_q[1:0] == 0) fin_result = prod_s[WIDTH-1:0];
    else                     fin_result = prod_s[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (pending) next_state = fast ? S_DONE : S_CALC;
      S_CALC: if (cnt == LAST_CNT) next_state = S_FIN;
      S_FIN:  next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      state  <= S_IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= next_state;
      o_busy <= (next_state == S_CALC) || (next_state == S_FIN);
      o_done <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending  <= 1'b0;
      cnt      <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      o_result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!pending) begin
            if (i_start) begin
              pending <= 1'b1;
              f3_q    <= i_funct3;
              a_q     <= i_op_a;
              b_q     <= i_op_b;
            end
          end else begin
            pending <= 1'b0;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            acc_hi  <= '0;
            // Multiply shifts the multiplier out of acc_lo; divide shifts the dividend out of it.
            acc_lo  <= f3_q[2] ? mag_a : mag_b;
            opnd    <= f3_q[2] ? mag_b : mag_a;
            if (fast) o_result <= fast_result;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (f3_q[2]) begin
            acc_hi <= div_take ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_take};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIN:   o_result <= fin_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Self-checking bench for mdu_seq_unit: directed vector table, multi-cycle corner sequences,
// and randomized operations compared with a plain-arithmetic RV32M reference.
module tb_mdu_seq_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_op_a, i_op_b;
  logic        o_busy, o_done;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_seq_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_funct3 (i_funct3),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RV32M semantics from plain arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    ref_mdu = '0;
    case (f3)
      3'd0: ref_mdu = a * b;
      3'd1: begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; p = xa * xb; ref_mdu = p[63:32]; end
      3'd2: begin xa = {{32{a[31]}}, a}; xb = {32'd0, b};       p = xa * xb; ref_mdu = p[63:32]; end
      3'd3: begin xa = {32'd0, a};       xb = {32'd0, b};       p = xa * xb; ref_mdu = p[63:32]; end
      3'd4: if (b == 0) ref_mdu = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_mdu = 32'h8000_0000;
            else ref_mdu = 32'(sa / sb);
      3'd5: ref_mdu = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) ref_mdu = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_mdu = 32'd0;
            else ref_mdu = 32'(sa % sb);
      default: ref_mdu = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request; scrambles the inputs after acceptance and optionally pulses a
  // spurious start with other operands at cycle glitch_k. Returns one cycle after done.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_k, output logic [31:0] res, output int done_k,
                       output int busy_n);
    i_funct3 = f3;
    i_op_a   = a;
    i_op_b   = b;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
    i_funct3 = ~f3;
    i_op_a   = $urandom;
    i_op_b   = $urandom;
    done_k = 0;
    busy_n = 0;
    res    = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (o_busy) busy_n++;
      if (o_done) begin
        done_k = k;
        res    = o_result;
        break;
      end
      i_start = (k == glitch_k);
    end
    i_start = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  int          done_k, busy_n, n_done;
  logic [2:0]  rf3;
  logic [31:0] ra, rb;

  initial begin
    i_reset  = 1'b1;
    i_start  = 1'b0;
    i_funct3 = '0;
    i_op_a   = '0;
    i_op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset result", 64'(o_result), 64'd0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{"mul 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulh min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
    vecs.push_back('{"mulhu max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{"mulhsu -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"div -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
    vecs.push_back('{"rem -7%2",        3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        34});
    vecs.push_back('{"remu 100%7",      3'd7, 32'd100,       32'd7,         32'd2,         34});
    vecs.push_back('{"divu by zero",    3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem by zero",     3'd6, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{"div overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"rem overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{"divu min/-1",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34});

    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 0, res, done_k, busy_n);
      check({vecs[i].name, " result"}, 64'(res), 64'(vecs[i].exp));
      check({vecs[i].name, " latency"}, 64'(done_k), 64'(vecs[i].lat));
      check({vecs[i].name, " busy cycles"}, 64'(busy_n), 64'(vecs[i].lat == 1 ? 0 : 33));
    end

    // Spurious start five cycles into CALC must be ignored and not queued.
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5, res, done_k, busy_n);
    check("ignored start result", 64'(res), 64'hFFFF_FFEB);
    check("ignored start latency", 64'(done_k), 64'd34);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) n_done++;
    end
    check("ignored start not queued", 64'(n_done), 64'd0);

    // Reset at CALC cycle 10 discards the operation.
    i_funct3 = 3'd0;
    i_op_a   = 32'h1234_5678;
    i_op_b   = 32'h0000_FFFF;
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
    end
    check("busy before reset", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("reset mid busy", 64'(o_busy), 64'd0);
    check("reset mid done", 64'(o_done), 64'd0);
    check("reset mid result", 64'(o_result), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (o_done) n_done++;
    end
    check("reset mid no done", 64'(n_done), 64'd0);
    do_op(3'd0, 32'd3, 32'd4, 0, res, done_k, busy_n);
    check("mul 3*4 after reset", 64'(res), 64'd12);
    check("mul 3*4 latency", 64'(done_k), 64'd34);

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      do_op(rf3, ra, rb, 0, res, done_k, busy_n);
      if (res !== ref_mdu(rf3, ra, rb))
        $display("  op f3=%0d a=0x%0h b=0x%0h", rf3, ra, rb);
      check("random result", 64'(res), 64'(ref_mdu(rf3, ra, rb)));
      check("random latency", 64'(done_k), 64'(ref_latency(rf3, ra, rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
